// File: rtl/immgen_pipe.sv
// -----------------------------------------------------------------------------
// immgen_pipe
// Registered, flow-controlled RISC-V immediate generator sitting between fetch
// and decode/execute. One instruction per cycle is accepted over valid/ready.
// The block decodes the immediate format, sign-extends the immediate to XLEN
// and forwards a sideband tag. A two-entry store lets it run at full rate while
// the consumer stalls:
//   - or_* registers : the output register, which drives the outputs
//   - sk_* registers : the skid register, which catches the word accepted in
//                      the cycle the consumer first stalls
// in_ready_o is a register, so there is no combinational path from out_ready_i.
//
// Optional feature (compile-time macro IMMGEN_ILLEGAL_EN):
//   defined   - illegal_o flags words whose low bits are not 2'b11 or whose
//               opcode is not recognised. Such words carry imm 0 and fmt NONE.
//               The flag is stored per entry and passes through the skid
//               register with the rest of the entry.
//   undefined - illegal_o is tied low and no flag storage is built.
// -----------------------------------------------------------------------------
module immgen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  imm_o,
    output logic [2:0]       fmt_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             illegal_o
);

    localparam bit IS_RV64 = (XLEN == 64);

    // Occupancy: how many results are held (0, 1 or 2).
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    // Major opcodes, instr[6:2].
    localparam logic [4:0] OPC_LOAD    = 5'b00000;
    localparam logic [4:0] OPC_OPIMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC   = 5'b00101;
    localparam logic [4:0] OPC_OPIMM32 = 5'b00110;
    localparam logic [4:0] OPC_STORE   = 5'b01000;
    localparam logic [4:0] OPC_LUI     = 5'b01101;
    localparam logic [4:0] OPC_BRANCH  = 5'b11000;
    localparam logic [4:0] OPC_JALR    = 5'b11001;
    localparam logic [4:0] OPC_JAL     = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM  = 5'b11100;

    // Returns {fmt, imm32}. imm32 is already sign-extended to 32 bits. The
    // XLEN extension is done separately so this function does not depend on
    // XLEN.
    function automatic logic [34:0] decode32(input logic [31:0] instr);
        logic [2:0]  fmt;
        logic [31:0] raw;
        fmt = FMT_NONE;
        raw = 32'd0;
        case (instr[6:2])
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM: begin
                fmt = FMT_I;
                raw = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_OPIMM32: begin
                // The *W immediate forms exist only on RV64.
                if (IS_RV64) begin
                    fmt = FMT_I;
                    raw = {{20{instr[31]}}, instr[31:20]};
                end else begin
                    fmt = FMT_NONE;
                    raw = 32'd0;
                end
            end
            OPC_STORE: begin
                fmt = FMT_S;
                raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                fmt = FMT_B;
                raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                       instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt = FMT_U;
                raw = {instr[31:12], 12'd0};
            end
            OPC_JAL: begin
                fmt = FMT_J;
                raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                       instr[30:21], 1'b0};
            end
            default: begin
                fmt = FMT_NONE;
                raw = 32'd0;
            end
        endcase
        return {fmt, raw};
    endfunction

`ifdef IMMGEN_ILLEGAL_EN
    // A word is legal when it is a 32-bit encoding (low bits 2'b11) with a
    // recognised opcode. OP-IMM-32 counts as recognised only on RV64.
    function automatic logic is_legal(input logic [31:0] instr);
        logic known;
        case (instr[6:2])
            OPC_LOAD, OPC_OPIMM, OPC_AUIPC, OPC_STORE, OPC_LUI,
            OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: known = 1'b1;
            OPC_OPIMM32: known = IS_RV64;
            default:     known = 1'b0;
        endcase
        return known & (instr[1:0] == 2'b11);
    endfunction
`endif

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             accept_s;
    logic             pop_s;
    logic             ld_or_new_s;
    logic             ld_or_sk_s;
    logic             ld_sk_s;

    logic [34:0]      dec_raw_s;
    logic [31:0]      dec_imm32_s;
    logic [2:0]       dec_fmt_s;
    logic [XLEN-1:0]  dec_imm_s;

    logic [XLEN-1:0]  or_imm_r;
    logic [2:0]       or_fmt_r;
    logic [TAG_W-1:0] or_tag_r;
    logic [XLEN-1:0]  sk_imm_r;
    logic [2:0]       sk_fmt_r;
    logic [TAG_W-1:0] sk_tag_r;

`ifdef IMMGEN_ILLEGAL_EN
    logic             dec_ill_s;
    logic             or_ill_r;
    logic             sk_ill_r;
`else
    // Low opcode bits only matter when the illegal check is built.
    logic             unused_instr_lsb_s;
    assign unused_instr_lsb_s = &{1'b0, instr_i[1:0]};
`endif

    assign accept_s = in_valid_i & in_ready_r;
    assign pop_s    = out_valid_r & out_ready_i;

    // Decode the incoming word and sign-extend its immediate to XLEN.
    always_comb begin
        dec_raw_s = decode32(instr_i);
`ifdef IMMGEN_ILLEGAL_EN
        dec_ill_s = ~is_legal(instr_i);
        if (dec_ill_s) begin
            dec_fmt_s   = FMT_NONE;
            dec_imm32_s = 32'd0;
        end else begin
            dec_fmt_s   = dec_raw_s[34:32];
            dec_imm32_s = dec_raw_s[31:0];
        end
`else
        dec_fmt_s   = dec_raw_s[34:32];
        dec_imm32_s = dec_raw_s[31:0];
`endif
        dec_imm_s = {XLEN{1'b0}};
        for (int i = 0; i < XLEN; i++) begin
            if (i < 32) begin
                dec_imm_s[i] = dec_imm32_s[i[4:0]];
            end else begin
                dec_imm_s[i] = dec_imm32_s[31];
            end
        end
    end

    // Occupancy next-state and register load enables. Flush wins over
    // everything.
    always_comb begin
        state_nxt_s = state_r;
        ld_or_new_s = 1'b0;
        ld_or_sk_s  = 1'b0;
        ld_sk_s     = 1'b0;
        if (flush_i) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        ld_or_new_s = 1'b1;
                        state_nxt_s = ST_ONE;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && pop_s) begin
                        ld_or_new_s = 1'b1;
                        state_nxt_s = ST_ONE;
                    end else if (accept_s) begin
                        ld_sk_s     = 1'b1;
                        state_nxt_s = ST_TWO;
                    end else if (pop_s) begin
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (pop_s) begin
                        ld_or_sk_s  = 1'b1;
                        state_nxt_s = ST_ONE;
                    end else begin
                        state_nxt_s = ST_TWO;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                end
            endcase
        end
    end

    // Occupancy state plus the registered handshake outputs derived from it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s != ST_TWO);
            out_valid_r <= (state_nxt_s != ST_EMPTY);
        end
    end

    // Output register: loads a new decode or the skid entry, else holds.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            or_imm_r <= {XLEN{1'b0}};
            or_fmt_r <= FMT_NONE;
            or_tag_r <= {TAG_W{1'b0}};
        end else if (ld_or_new_s) begin
            or_imm_r <= dec_imm_s;
            or_fmt_r <= dec_fmt_s;
            or_tag_r <= tag_i;
        end else if (ld_or_sk_s) begin
            or_imm_r <= sk_imm_r;
            or_fmt_r <= sk_fmt_r;
            or_tag_r <= sk_tag_r;
        end else begin
            or_imm_r <= or_imm_r;
            or_fmt_r <= or_fmt_r;
            or_tag_r <= or_tag_r;
        end
    end

    // Skid register: captures the word accepted while the output is stalled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sk_imm_r <= {XLEN{1'b0}};
            sk_fmt_r <= FMT_NONE;
            sk_tag_r <= {TAG_W{1'b0}};
        end else if (ld_sk_s) begin
            sk_imm_r <= dec_imm_s;
            sk_fmt_r <= dec_fmt_s;
            sk_tag_r <= tag_i;
        end else begin
            sk_imm_r <= sk_imm_r;
            sk_fmt_r <= sk_fmt_r;
            sk_tag_r <= sk_tag_r;
        end
    end

`ifdef IMMGEN_ILLEGAL_EN
    // Per-entry illegal flag, moved with the output and skid registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            or_ill_r <= 1'b0;
            sk_ill_r <= 1'b0;
        end else begin
            if (ld_or_new_s) begin
                or_ill_r <= dec_ill_s;
            end else if (ld_or_sk_s) begin
                or_ill_r <= sk_ill_r;
            end else begin
                or_ill_r <= or_ill_r;
            end
            if (ld_sk_s) begin
                sk_ill_r <= dec_ill_s;
            end else begin
                sk_ill_r <= sk_ill_r;
            end
        end
    end

    assign illegal_o = or_ill_r;
`else
    assign illegal_o = 1'b0;
`endif

    assign in_ready_o  = in_ready_r;
    assign out_valid_o = out_valid_r;
    assign imm_o       = or_imm_r;
    assign fmt_o       = or_fmt_r;
    assign tag_o       = or_tag_r;

endmodule

// File: tb/tb_immgen_pipe.sv
// -----------------------------------------------------------------------------
// tb_immgen_pipe
// Drives an XLEN=32 and an XLEN=64 instance with identical stimulus. Expected
// results come from an arithmetic reference decoder and a FIFO scoreboard of
// accepted words. The expected illegal behaviour follows IMMGEN_ILLEGAL_EN.
// -----------------------------------------------------------------------------
module tb_immgen_pipe;

    localparam int TAG_W = 5;
`ifdef IMMGEN_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic [31:0]      instr = 32'd0;
    logic [TAG_W-1:0] tag = '0;
    logic             out_ready = 1'b0;

    logic             rdy32, vld32, ill32;
    logic [31:0]      imm32;
    logic [2:0]       fmt32;
    logic [TAG_W-1:0] tag32;
    logic             rdy64, vld64, ill64;
    logic [63:0]      imm64;
    logic [2:0]       fmt64;
    logic [TAG_W-1:0] tag64;

    immgen_pipe #(.XLEN(32), .TAG_W(TAG_W)) u32 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(rdy32), .instr_i(instr), .tag_i(tag), .out_valid_o(vld32),
        .out_ready_i(out_ready), .imm_o(imm32), .fmt_o(fmt32), .tag_o(tag32),
        .illegal_o(ill32));

    immgen_pipe #(.XLEN(64), .TAG_W(TAG_W)) u64 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(rdy64), .instr_i(instr), .tag_i(tag), .out_valid_o(vld64),
        .out_ready_i(out_ready), .imm_o(imm64), .fmt_o(fmt64), .tag_o(tag64),
        .illegal_o(ill64));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      instr;
        logic [TAG_W-1:0] tag;
    } entry_t;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } ref_t;

    entry_t exp_q[$];
    int     vectors = 0;
    int     errors  = 0;

    // Interprets a bit field as a two's complement number of the given width.
    function automatic longint as_signed(input longint raw, input int width);
        longint half;
        half = longint'(1) <<< (width - 1);
        if (raw >= half) return raw - (half <<< 1);
        else             return raw;
    endfunction

    // Reference decoder: immediates are assembled arithmetically from field
    // values and then interpreted as signed numbers.
    function automatic ref_t ref_decode(input logic [31:0] w, input bit rv64);
        ref_t   r;
        longint v;
        int     op;
        bit     known;
        op    = int'(w[6:2]);
        known = 1'b1;
        v     = 0;
        r.fmt = 3'd0;
        case (op)
            0, 4, 25, 28: begin
                r.fmt = 3'd1;
                v = as_signed(longint'(w[31:20]), 12);
            end
            6: begin
                if (rv64) begin
                    r.fmt = 3'd1;
                    v = as_signed(longint'(w[31:20]), 12);
                end else begin
                    known = 1'b0;
                end
            end
            8: begin
                r.fmt = 3'd2;
                v = as_signed(longint'(w[31:25]) * 32 + longint'(w[11:7]), 12);
            end
            24: begin
                r.fmt = 3'd3;
                v = as_signed(longint'(w[31]) * 4096 + longint'(w[7]) * 2048 +
                              longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2, 13);
            end
            13, 5: begin
                r.fmt = 3'd4;
                v = as_signed(longint'(w[31:12]) * 4096, 32);
            end
            27: begin
                r.fmt = 3'd5;
                v = as_signed(longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096 +
                              longint'(w[20]) * 2048 + longint'(w[30:21]) * 2, 21);
            end
            default: known = 1'b0;
        endcase
        r.ill = ILL_EN && (!known || (w[1:0] != 2'b11));
        if (r.ill) begin
            r.fmt = 3'd0;
            v = 0;
        end
        r.imm = v;
        return r;
    endfunction

    // Advances one clock and updates the scoreboard from the handshakes seen
    // just before the edge. Outputs are then sampled 1 time unit after it.
    task automatic step();
        bit     acc, pop;
        entry_t e;
        acc = in_valid && rdy32;
        pop = vld32 && out_ready;
        e.instr = instr;
        e.tag   = tag;
        @(posedge clk);
        if (flush) begin
            exp_q.delete();
        end else begin
            if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(e);
        end
        #1;
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        instr = 32'hFFF00093;
        rst_n = 1'b0;
        step();
        step();
        vectors++; if (vld32 !== 1'b0 || vld64 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b/%b exp 0", vld32, vld64); end
        vectors++; if (rdy32 !== 1'b0 || rdy64 !== 1'b0) begin errors++; $display("FAIL reset_ready got %b/%b exp 0", rdy32, rdy64); end
        vectors++; if (imm32 !== 32'd0 || imm64 !== 64'd0 || fmt32 !== 3'd0 || tag32 !== '0 || ill32 !== 1'b0)
            begin errors++; $display("FAIL reset_outputs imm %h fmt %0d tag %0d ill %b exp zeros", imm32, fmt32, tag32, ill32); end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        vectors++; if (rdy32 !== 1'b1 || rdy64 !== 1'b1) begin errors++; $display("FAIL release_ready got %b/%b exp 1", rdy32, rdy64); end
        vectors++; if (vld32 !== 1'b0) begin errors++; $display("FAIL release_valid got %b exp 0", vld32); end
    endtask

    task automatic test_formats();
        logic [31:0] words [5] = '{32'hFFF00093, 32'hFE112E23, 32'h00000463, 32'h123452B7, 32'hFF9FF06F};
        logic [31:0] imms  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000008, 32'h12345000, 32'hFFFFFFF8};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            instr = words[i];
            tag = TAG_W'(i + 10);
            step();
            vectors++; if (vld32 !== 1'b1 || imm32 !== imms[i] || fmt32 !== 3'(i + 1) || tag32 !== TAG_W'(i + 10))
                begin errors++; $display("FAIL fmt_%0d valid %b imm %h fmt %0d tag %0d exp 1 %h %0d %0d",
                                         i, vld32, imm32, fmt32, tag32, imms[i], i + 1, i + 10); end
            vectors++; if (imm64 !== {{32{imms[i][31]}}, imms[i]}) begin errors++; $display("FAIL fmt64_%0d imm %h", i, imm64); end
        end
        in_valid = 1'b0;
        step();
        vectors++; if (vld32 !== 1'b0) begin errors++; $display("FAIL drain_valid got %b exp 0", vld32); end
    endtask

    task automatic test_backpressure();
        logic [TAG_W-1:0] got[$];
        bit               sent3;
        logic [31:0]      held_imm;
        out_ready = 1'b0;
        in_valid = 1'b1;
        instr = 32'h00500093;
        tag = 5'd1;
        step();
        vectors++; if (rdy32 !== 1'b1 || vld32 !== 1'b1 || tag32 !== 5'd1) begin errors++; $display("FAIL bp_one rdy %b vld %b tag %0d exp 1 1 1", rdy32, vld32, tag32); end
        instr = 32'h00600113;
        tag = 5'd2;
        step();
        vectors++; if (rdy32 !== 1'b0 || tag32 !== 5'd1) begin errors++; $display("FAIL bp_two rdy %b tag %0d exp 0 1", rdy32, tag32); end
        held_imm = imm32;
        instr = 32'h00700193;
        tag = 5'd3;
        step();
        step();
        vectors++; if (rdy32 !== 1'b0 || tag32 !== 5'd1 || imm32 !== held_imm || vld32 !== 1'b1)
            begin errors++; $display("FAIL bp_hold rdy %b tag %0d imm %h exp 0 1 %h", rdy32, tag32, imm32, held_imm); end
        out_ready = 1'b1;
        sent3 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (vld32) got.push_back(tag32);
            if (in_valid && rdy32) sent3 = 1'b1;
            step();
            if (sent3) in_valid = 1'b0;
        end
        vectors++; if (got.size() != 3) begin errors++; $display("FAIL bp_count got %0d exp 3", got.size()); end
        else begin
            vectors++; if (got[0] !== 5'd1 || got[1] !== 5'd2 || got[2] !== 5'd3)
                begin errors++; $display("FAIL bp_order got %0d %0d %0d exp 1 2 3", got[0], got[1], got[2]); end
        end
        vectors++; if (rdy32 !== 1'b1) begin errors++; $display("FAIL bp_after_ready got %b exp 1", rdy32); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1;
        instr = 32'h00100093; tag = 5'd4; step();
        instr = 32'h00200093; tag = 5'd5; step();
        vectors++; if (rdy32 !== 1'b0) begin errors++; $display("FAIL flush_pre_two rdy %b exp 0", rdy32); end
        instr = 32'h00300093; tag = 5'd7;
        flush = 1'b1;
        step();
        flush = 1'b0;
        vectors++; if (vld32 !== 1'b0 || rdy32 !== 1'b1) begin errors++; $display("FAIL flush_state vld %b rdy %b exp 0 1", vld32, rdy32); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            vectors++; if (vld32 !== 1'b0 || vld64 !== 1'b0) begin errors++; $display("FAIL flush_leak cyc %0d vld %b tag %0d exp 0", c, vld32, tag32); end
        end
    endtask

    task automatic test_xlen64();
        out_ready = 1'b1;
        in_valid = 1'b1;
        instr = 32'h800002B7;
        step();
        vectors++; if (imm64 !== 64'hFFFFFFFF80000000 || fmt64 !== 3'd4) begin errors++; $display("FAIL lui64 imm %h fmt %0d exp ffffffff80000000 4", imm64, fmt64); end
        vectors++; if (imm32 !== 32'h80000000) begin errors++; $display("FAIL lui32 imm %h exp 80000000", imm32); end
        instr = 32'hFFF0009B;
        step();
        vectors++; if (fmt64 !== 3'd1 || imm64 !== 64'hFFFFFFFFFFFFFFFF || ill64 !== 1'b0)
            begin errors++; $display("FAIL opimm32_64 fmt %0d imm %h ill %b exp 1 all-ones 0", fmt64, imm64, ill64); end
        vectors++; if (fmt32 !== 3'd0 || imm32 !== 32'd0 || ill32 !== ILL_EN)
            begin errors++; $display("FAIL opimm32_32 fmt %0d imm %h ill %b exp 0 0 %b", fmt32, imm32, ill32, ILL_EN); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        in_valid = 1'b1;
        instr = 32'h00000000;
        step();
        vectors++; if (ill32 !== ILL_EN || ill64 !== ILL_EN || imm32 !== 32'd0 || fmt32 !== (ILL_EN ? 3'd0 : 3'd1))
            begin errors++; $display("FAIL ill_zero ill %b imm %h fmt %0d exp %b 0 %0d", ill32, imm32, fmt32, ILL_EN, ILL_EN ? 0 : 1); end
        instr = 32'h0000007F;
        step();
        vectors++; if (ill32 !== ILL_EN || ill64 !== ILL_EN || imm32 !== 32'd0 || fmt32 !== 3'd0)
            begin errors++; $display("FAIL ill_7f ill %b imm %h fmt %0d exp %b 0 0", ill32, imm32, fmt32, ILL_EN); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_random();
        logic [4:0] ops [12] = '{5'b00000, 5'b00100, 5'b11001, 5'b11100, 5'b00110, 5'b01000,
                                 5'b11000, 5'b01101, 5'b00101, 5'b11011, 5'b01100, 5'b11111};
        ref_t r32, r64;
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 39) == 0);
            instr     = $urandom();
            instr[6:2] = ops[$urandom_range(0, 11)];
            if ($urandom_range(0, 7) != 0) instr[1:0] = 2'b11;
            tag = TAG_W'($urandom());
            step();
            vectors++; if (vld32 !== (exp_q.size() != 0) || vld64 !== vld32)
                begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", c, vld32, exp_q.size() != 0); end
            vectors++; if (rdy32 !== (exp_q.size() < 2) || rdy64 !== rdy32)
                begin errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", c, rdy32, exp_q.size() < 2); end
            if (exp_q.size() != 0) begin
                r32 = ref_decode(exp_q[0].instr, 1'b0);
                r64 = ref_decode(exp_q[0].instr, 1'b1);
                vectors++; if (imm32 !== r32.imm[31:0] || fmt32 !== r32.fmt || ill32 !== r32.ill || tag32 !== exp_q[0].tag)
                    begin errors++; $display("FAIL rnd_data32 cyc %0d w %h got %h/%0d/%b/%0d exp %h/%0d/%b/%0d", c, exp_q[0].instr,
                                             imm32, fmt32, ill32, tag32, r32.imm[31:0], r32.fmt, r32.ill, exp_q[0].tag); end
                vectors++; if (imm64 !== r64.imm || fmt64 !== r64.fmt || ill64 !== r64.ill || tag64 !== exp_q[0].tag)
                    begin errors++; $display("FAIL rnd_data64 cyc %0d w %h got %h/%0d/%b exp %h/%0d/%b", c, exp_q[0].instr,
                                             imm64, fmt64, ill64, r64.imm, r64.fmt, r64.ill); end
            end
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step(); step(); step();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        instr = 32'h12345037; tag = 5'd9; step();
        instr = 32'h00a00093; tag = 5'd10; step();
        vectors++; if (rdy32 !== 1'b0 || vld32 !== 1'b1) begin errors++; $display("FAIL ar_pre rdy %b vld %b exp 0 1", rdy32, vld32); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (vld32 !== 1'b0 || vld64 !== 1'b0 || rdy32 !== 1'b0 || imm32 !== 32'd0 || tag32 !== '0 || fmt32 !== 3'd0)
            begin errors++; $display("FAIL ar_async vld %b rdy %b imm %h tag %0d fmt %0d exp 0 0 0 0 0", vld32, rdy32, imm32, tag32, fmt32); end
        exp_q.delete();
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        vectors++; if (vld32 !== 1'b0 || rdy32 !== 1'b1) begin errors++; $display("FAIL ar_release vld %b rdy %b exp 0 1", vld32, rdy32); end
        step();
        vectors++; if (vld32 !== 1'b0 || vld64 !== 1'b0) begin errors++; $display("FAIL ar_stale vld %b tag %0d exp 0", vld32, tag32); end
    endtask

    initial begin
        test_reset();
        test_formats();
        test_backpressure();
        test_flush();
        test_xlen64();
        test_illegal();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
